// File: rtl/aes_hmac_rx_collector_pkg.sv
// Shared types and constants for the AES/HMAC result collector.
package aes_hmac_rx_collector_pkg;

    localparam int CIPHER_BYTES = 16;
    localparam int MAC_BYTES    = 32;

    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_GAP   = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CIPHER,
        ST_GAP,
        ST_MAC,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/aes_hmac_rx_collector_rx_gap_timer.sv
// Counts consecutive idle cycles; expire is combinational on the GAP_MAX-th increment.
// Clears on clr or on expiry so the next gap always starts from zero.
module rx_gap_timer #(
    parameter int GAP_MAX = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int TW = $clog2(GAP_MAX);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expire = inc && (cnt_q == TW'(GAP_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_hmac_rx_collector.sv
// Deserializes 16 cipher + 32 MAC bytes into one frame; o_valid one cycle after the last byte.
// Frame held until i_ready; bytes arriving while held and not consumed are dropped as overflow.
module aes_hmac_rx_collector
    import aes_hmac_rx_collector_pkg::*;
#(
    parameter int GAP_MAX = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   i_data,
    input  logic         i_valid,
    output logic [127:0] o_cipher,
    output logic [255:0] o_mac,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_err,
    output logic [1:0]   o_err_code,
    output logic         o_busy
);
    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [127:0]   cipher_q, cipher_d;
    logic [255:0]   mac_q, mac_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [1:0]     code_q, code_d;
    logic           busy_q, busy_d;
    logic           gap_inc;
    logic           gap_expire;

    rx_gap_timer #(.GAP_MAX(GAP_MAX)) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!gap_inc),
        .inc    (gap_inc),
        .expire (gap_expire)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cipher_d = cipher_q;
        mac_d    = mac_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        code_d   = code_q;
        gap_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    cipher_d[7:0] = i_data;
                    cnt_d         = 5'd1;
                    state_d       = ST_CIPHER;
                end
            end
            ST_CIPHER: begin
                if (i_valid) begin
                    cipher_d[{cnt_q[3:0], 3'b000} +: 8] = i_data;
                    if (cnt_q == 5'(CIPHER_BYTES - 1)) begin
                        cnt_d   = 5'd0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    code_d  = ERR_SHORT;
                    cnt_d   = 5'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (i_valid) begin
                    mac_d[7:0] = i_data;
                    cnt_d      = 5'd1;
                    state_d    = ST_MAC;
                end else begin
                    gap_inc = 1'b1;
                    if (gap_expire) begin
                        err_d   = 1'b1;
                        code_d  = ERR_GAP;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MAC: begin
                if (i_valid) begin
                    mac_d[{cnt_q, 3'b000} +: 8] = i_data;
                    if (cnt_q == 5'(MAC_BYTES - 1)) begin
                        cnt_d   = 5'd0;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    code_d  = ERR_SHORT;
                    cnt_d   = 5'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    // Same-cycle consume lets a back-to-back stream start the next frame here.
                    if (i_valid) begin
                        cipher_d[7:0] = i_data;
                        cnt_d         = 5'd1;
                        state_d       = ST_CIPHER;
                    end
                end else if (i_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVF;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            cipher_q <= '0;
            mac_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cipher_q <= cipher_d;
            mac_q    <= mac_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            code_q   <= code_d;
            busy_q   <= busy_d;
        end
    end

    assign o_cipher   = cipher_q;
    assign o_mac      = mac_q;
    assign o_valid    = valid_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_aes_hmac_rx_collector.sv
// Scoreboard bench: stimulus pushes expected frames/error codes, a negedge monitor pops and compares.
module tb_aes_hmac_rx_collector;
    localparam int GAP = 48;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   i_data = 8'h00;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [127:0] o_cipher;
    logic [255:0] o_mac;
    logic         o_valid;
    logic         o_err;
    logic [1:0]   o_err_code;
    logic         o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] exp_c_q[$];
    logic [255:0] exp_m_q[$];
    logic [1:0]   exp_e_q[$];

    always #5 clk = ~clk;

    aes_hmac_rx_collector #(.GAP_MAX(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_cipher   (o_cipher),
        .o_mac      (o_mac),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .o_busy     (o_busy)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake and error pulses observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) begin
                if (exp_c_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got cipher %h, expected no frame", o_cipher);
                end else begin
                    check("frame_cipher", 256'(o_cipher), 256'(exp_c_q.pop_front()));
                    check("frame_mac", o_mac, exp_m_q.pop_front());
                end
            end
            if (o_err) begin
                if (exp_e_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_err: got code %0d, expected no error", o_err_code);
                end else begin
                    check("err_code", 256'(o_err_code), 256'(exp_e_q.pop_front()));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_c();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] rand_m();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sends cipher bytes from index 'first', a gap, then all MAC bytes.
    task automatic send_frame(input logic [127:0] c, input logic [255:0] m, input int gap,
                              input logic r, input int first);
        if (first == 0) begin
            exp_c_q.push_back(c);
            exp_m_q.push_back(m);
        end
        for (int i = first; i < 16; i++) cyc(1'b1, c[8*i +: 8], r);
        for (int i = 0; i < gap; i++) cyc(1'b0, 8'h00, r);
        for (int i = 0; i < 32; i++) cyc(1'b1, m[8*i +: 8], r);
    endtask

    // k dropped bytes while the frame is held, then a plain consume.
    task automatic drain(input int k);
        for (int i = 0; i < k; i++) begin
            exp_e_q.push_back(2'd3);
            cyc(1'b1, 8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) cyc(1'b0, 8'h00, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cipher"}, 256'(o_cipher), 256'd0);
        check({tag, "_mac"}, o_mac, 256'd0);
        check({tag, "_valid"}, 256'(o_valid), 256'd0);
        check({tag, "_err"}, 256'(o_err), 256'd0);
        check({tag, "_code"}, 256'(o_err_code), 256'd0);
        check({tag, "_busy"}, 256'(o_busy), 256'd0);
    endtask

    initial begin
        logic [127:0] c;
        logic [255:0] m;
        int kind;

        #1;
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        check_zero("reset");
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);

        // Nominal frame: counting bytes, long gap, consumer initially not ready.
        for (int i = 0; i < 16; i++) c[8*i +: 8] = 8'(i);
        for (int i = 0; i < 32; i++) m[8*i +: 8] = 8'(16 + i);
        send_frame(c, m, 40, 1'b0, 0);
        check("nominal_valid", 256'(o_valid), 256'd1);
        check("nominal_busy_hold", 256'(o_busy), 256'd0);
        check("nominal_cipher", 256'(o_cipher), 256'(128'h0f0e0d0c0b0a09080706050403020100));
        cyc(1'b0, 8'h00, 1'b1);
        check("nominal_valid_fall", 256'(o_valid), 256'd0);

        // Short cipher burst then a clean frame.
        exp_e_q.push_back(2'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("short_err", 256'(o_err), 256'd1);
        check("short_code", 256'(o_err_code), 256'd1);
        check("short_busy", 256'(o_busy), 256'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("short_err_pulse", 256'(o_err), 256'd0);
        send_frame(rand_c(), rand_m(), 3, 1'b0, 0);
        drain(0);

        // Gap boundary: GAP-1 idle cycles are legal, GAP idle cycles time out.
        send_frame(rand_c(), rand_m(), GAP - 1, 1'b0, 0);
        drain(0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < GAP - 1; i++) cyc(1'b0, 8'h00, 1'b0);
        check("gap_no_err_yet", 256'(o_err), 256'd0);
        check("gap_busy", 256'(o_busy), 256'd1);
        exp_e_q.push_back(2'd2);
        cyc(1'b0, 8'h00, 1'b0);
        check("gap_err", 256'(o_err), 256'd1);
        check("gap_code", 256'(o_err_code), 256'd2);
        cyc(1'b0, 8'h00, 1'b0);
        check("gap_err_pulse", 256'(o_err), 256'd0);

        // Overflow: three dropped bytes, frame must survive intact.
        send_frame(rand_c(), rand_m(), 0, 1'b0, 0);
        drain(3);
        check("ovf_code_held", 256'(o_err_code), 256'd3);
        check("ovf_valid_fall", 256'(o_valid), 256'd0);

        // Consume and new byte in the same cycle.
        send_frame(rand_c(), rand_m(), 5, 1'b0, 0);
        c = rand_c();
        c[7:0] = 8'hAA;
        m = rand_m();
        exp_c_q.push_back(c);
        exp_m_q.push_back(m);
        cyc(1'b1, 8'hAA, 1'b1);
        check("simul_valid", 256'(o_valid), 256'd0);
        check("simul_busy", 256'(o_busy), 256'd1);
        check("simul_byte0", 256'(o_cipher[7:0]), 256'(8'hAA));
        send_frame(c, m, 2, 1'b0, 1);
        drain(0);

        // Back-to-back stream with ready held high: exactly 48 cycles per frame.
        for (int f = 0; f < 3; f++) send_frame(rand_c(), rand_m(), 0, 1'b1, 0);
        check("b2b_valid", 256'(o_valid), 256'd1);
        cyc(1'b0, 8'h00, 1'b1);

        // Reset at MAC byte 20, then a clean frame.
        c = rand_c();
        m = rand_m();
        for (int i = 0; i < 16; i++) cyc(1'b1, c[8*i +: 8], 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, m[8*i +: 8], 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 8'h55, 1'b0);
        check_zero("midreset");
        rst_n = 1'b1;
        send_frame(rand_c(), rand_m(), 1, 1'b0, 0);
        drain(1);

        // Randomized mix of legal frames and every error class.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_frame(rand_c(), rand_m(), $urandom_range(0, GAP - 1), 1'b0, 0);
                drain($urandom_range(0, 3));
            end else if (kind == 6) begin
                exp_e_q.push_back(2'd1);
                for (int i = 0; i < $urandom_range(1, 15); i++) cyc(1'b1, 8'($urandom), 1'b0);
                cyc(1'b0, 8'h00, 1'b0);
            end else if (kind == 7) begin
                exp_e_q.push_back(2'd1);
                for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0);
                for (int i = 0; i < $urandom_range(0, 10); i++) cyc(1'b0, 8'h00, 1'b0);
                for (int i = 0; i < $urandom_range(1, 31); i++) cyc(1'b1, 8'($urandom), 1'b0);
                cyc(1'b0, 8'h00, 1'b0);
            end else begin
                exp_e_q.push_back(2'd2);
                for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0);
                for (int i = 0; i < GAP; i++) cyc(1'b0, 8'h00, 1'b0);
            end
            for (int i = 0; i < $urandom_range(0, 2); i++) cyc(1'b0, 8'h00, 1'b0);
        end

        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        check("frames_left", 256'(exp_c_q.size()), 256'd0);
        check("errs_left", 256'(exp_e_q.size()), 256'd0);
        check("idle_end_valid", 256'(o_valid), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
